wide_add_sequencer: RTL and testbench
=====================================

Name: wide_add_sequencer

Overview:
- Multi-cycle, multi-precision add/subtract controller.
- Reuses one 16-bit carry-ripple adder slice, processing one 16-bit word per cycle from LSW to MSW and chaining the carry through a register.
- Sits between the operand source (switch/register file) and the result display/consumer, trading latency for area.
- Start/Done handshake follows lab convention: Start is a held level, and Done holds until Start is released.

Parameters:
- N_WORDS, 4, number of 16-bit words per operand (total width W = 16*N_WORDS); legal range 2..8.

Ports:
- Clk      in   1   system clock, rising edge
- Reset    in   1   asynchronous, active-high reset
- Start    in   1   level request; sampled only in IDLE
- Sub      in   1   0 = A+B, 1 = A-B; sampled with Start
- A        in   W   operand A; sampled with Start
- B        in   W   operand B; sampled with Start
- S        out  W   registered result; updated once per operation
- C_out    out  1   final carry (Sub=1: 1 = no borrow)
- V        out  1   two's-complement overflow of the W-bit result
- Busy     out  1   high while words are being added
- Done     out  1   high from completion until Start is released

Behaviour:
- Clocking and reset:
  - One clock; reset is asynchronous and active-high.
  - Reset forces state IDLE, clears all internal registers, and drives S=0, C_out=0, V=0, Busy=0, Done=0.
- FSM states: IDLE, ADD, DONE.
- IDLE:
  - Start=1 at an edge (the load edge): latch A into a_sh, latch B^{W{Sub}} into b_sh, set carry<=Sub, k<=0, then go to ADD.
  - Start=0: stay in IDLE.
- ADD:
  - Each cycle the adder slice sees a_sh[15:0], b_sh[15:0] and carry.
  - Each edge: shift the slice sum into the top of acc, shift a_sh and b_sh right by 16, set carry<=slice c_out, k<=k+1.
  - Busy=1 throughout ADD.
  - When k=N_WORDS-1, that edge also loads S<=final acc, C_out<=slice c_out, V<=overflow, then goes to DONE.
- Latency:
  - Exactly N_WORDS edges after the load edge, Done=1 and S/C_out/V are valid.
  - With the default parameter, Done rises 4 cycles after the load edge.
- Overflow rule: V = (A[W-1] == Bx[W-1]) && (Sum[W-1] != A[W-1]), where Bx is B after conditional inversion. The MSB values are captured at load and at the final word.
- DONE:
  - Done=1; S, C_out and V are held.
  - Start=0 moves to IDLE next edge; Done drops and outputs keep their values.
  - Start=1 stays in DONE, so there is no automatic re-trigger.
- Input changes:
  - A, B and Sub changes after the load edge are ignored until the next operation.
  - Start deasserted during ADD is ignored; the operation completes and Done pulses for at least one cycle.
- Output stability: S, C_out and V change only on the completion edge or on reset; they never show partial sums.
- Reset mid-operation:
  - The operation is abandoned and outputs are cleared asynchronously.
  - If Start is still high after reset release, a fresh operation loads on the first edge.
- Width rules:
  - Carry chain is 1 bit; k is a $clog2(N_WORDS)-bit counter.
  - Result width is W and the carry beyond W appears only on C_out.
- Subtract of equal operands gives S=0 and C_out=1.

Decomposition:
- Package wide_add_pkg holds:
  - WORD_W=16
  - state typedef enum logic [1:0] {IDLE, ADD, DONE}
- Sub-module: one instance of the team's 16-bit carry_ripple_unit as the word slice.
- FSM, shift registers and result registers stay in wide_add_sequencer.

Test Plan (N_WORDS=4):
- Reset: assert Reset mid-cycle with arbitrary inputs -> S=0, C_out=0, V=0, Busy=0, Done=0 immediately, with no clock needed.
- Cross-word carry: A=0x0000_0000_0000_FFFF, B=0x1, Sub=0, Start held -> Busy for 4 cycles; Done on cycle 4 after load; S=0x0000_0000_0001_0000, C_out=0, V=0.
- Full wrap: A=0xFFFF_FFFF_FFFF_FFFF, B=0x1 -> S=0, C_out=1, V=0.
- Subtract with borrow: A=5, B=7, Sub=1 -> S=0xFFFF_FFFF_FFFF_FFFE, C_out=0, V=0. Also A=7, B=7, Sub=1 -> S=0, C_out=1.
- Signed overflow: A=0x7FFF_FFFF_FFFF_FFFF, B=0x1, Sub=0 -> S=0x8000_0000_0000_0000, V=1, C_out=0.
  - Change A and B during ADD: result is unchanged.
  - Hold Start after Done: no second operation.
  - Release Start: IDLE next edge; S is held.
- Reset mid-op: assert Reset at k=2 with Start still high -> outputs cleared. After release, a new operation starts on the first edge and the correct result appears 4 cycles later.

Source files
------------

// File: rtl/wide_add_sequencer_pkg.sv
// Shared types and constants for the word-serial multi-precision adder.
package wide_add_pkg;

    localparam int unsigned WORD_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/wide_add_sequencer_if.sv
// Operand/result handshake bundle between the operand source and the sequencer.
interface wide_add_sequencer_if #(
    parameter int N_WORDS = 4
);
    localparam int W = 16 * N_WORDS;

    logic         Start;
    logic         Sub;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic [W-1:0] S;
    logic         C_out;
    logic         V;
    logic         Busy;
    logic         Done;

    modport master (
        output Start, Sub, A, B,
        input  S, C_out, V, Busy, Done
    );

    modport slave (
        input  Start, Sub, A, B,
        output S, C_out, V, Busy, Done
    );
endinterface

// File: rtl/wide_add_sequencer_slice.sv
// 16-bit carry-ripple adder slice, the one arithmetic unit the sequencer reuses.
module carry_ripple_unit
    import wide_add_pkg::*;
(
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    input  logic              c_in,
    output logic [WORD_W-1:0] sum,
    output logic              c_out
);
    // Bit-serial ripple of the carry from LSB to MSB.
    always_comb begin
        logic c;
        sum = '0;
        c   = c_in;
        for (int unsigned i = 0; i < WORD_W; i++) begin
            sum[i] = a[i] ^ b[i] ^ c;
            c      = (a[i] & b[i]) | (a[i] & c) | (b[i] & c);
        end
        c_out = c;
    end
endmodule

// File: rtl/wide_add_sequencer.sv
// Multi-precision add/subtract: one 16-bit slice, one word per cycle LSW->MSW.
module wide_add_sequencer
    import wide_add_pkg::*;
#(
    parameter int N_WORDS = 4
) (
    input  logic               Clk,
    input  logic               Reset,
    wide_add_sequencer_if.slave bus
);
    localparam int W   = WORD_W * N_WORDS;
    localparam int K_W = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;

    state_t         state, state_nx;
    logic [W-1:0]   a_sh, b_sh, acc, acc_nx;
    logic           carry;
    logic [K_W-1:0] k;
    logic [WORD_W-1:0] slice_sum;
    logic           slice_c;
    logic           last_word;

    carry_ripple_unit u_slice (
        .a     (a_sh[WORD_W-1:0]),
        .b     (b_sh[WORD_W-1:0]),
        .c_in  (carry),
        .sum   (slice_sum),
        .c_out (slice_c)
    );

    assign last_word = (k == K_W'(N_WORDS - 1));
    assign acc_nx    = {slice_sum, acc[W-1:WORD_W]};

    // State register.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Next-state: Start is a held level, so DONE waits for its release.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.Start) state_nx = ADD;
            ADD:     if (last_word) state_nx = DONE;
            DONE:    if (!bus.Start) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Status outputs decoded from state.
    always_comb begin
        bus.Busy = (state == ADD);
        bus.Done = (state == DONE);
    end

    // Operand shifters, carry chain, accumulator and result registers.
    // At the last word a_sh/b_sh hold the top operand words, so their MSBs
    // are A[W-1] and Bx[W-1] for the overflow test.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            a_sh      <= '0;
            b_sh      <= '0;
            acc       <= '0;
            carry     <= 1'b0;
            k         <= '0;
            bus.S     <= '0;
            bus.C_out <= 1'b0;
            bus.V     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.Start) begin
                        a_sh  <= bus.A;
                        b_sh  <= bus.B ^ {W{bus.Sub}};
                        carry <= bus.Sub;
                        k     <= '0;
                    end
                end
                ADD: begin
                    acc   <= acc_nx;
                    a_sh  <= a_sh >> WORD_W;
                    b_sh  <= b_sh >> WORD_W;
                    carry <= slice_c;
                    k     <= k + K_W'(1);
                    if (last_word) begin
                        bus.S     <= acc_nx;
                        bus.C_out <= slice_c;
                        bus.V     <= (a_sh[WORD_W-1] == b_sh[WORD_W-1]) &&
                                     (slice_sum[WORD_W-1] != a_sh[WORD_W-1]);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_wide_add_sequencer.sv
// Directed self-checking bench for wide_add_sequencer with N_WORDS=4.
module tb_wide_add_sequencer;
    localparam int N = 4;
    localparam int W = 16 * N;

    logic Clk;
    logic Reset;
    int   checks;
    int   failures;

    wide_add_sequencer_if #(.N_WORDS(N)) bus ();

    wide_add_sequencer #(.N_WORDS(N)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Launch one operation, scramble inputs after the load edge, wait for Done.
    task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic sub, input logic [W-1:0] exp_s,
                         input logic exp_c, input logic exp_v);
        logic [W-1:0] prev_s;
        int n;
        bus.A = a; bus.B = b; bus.Sub = sub; bus.Start = 1'b1;
        prev_s = bus.S;
        tick();
        bus.A = {$urandom, $urandom};
        bus.B = {$urandom, $urandom};
        bus.Sub = ~sub;
        check({tag, "_busy"}, W'(bus.Busy), W'(1));
        n = 0;
        while (!bus.Done && n < 20) begin
            check({tag, "_no_partial"}, bus.S, prev_s);
            tick();
            n++;
        end
        check({tag, "_latency"}, W'(n), W'(N));
        check({tag, "_done"}, W'(bus.Done), W'(1));
        check({tag, "_S"}, bus.S, exp_s);
        check({tag, "_C"}, W'(bus.C_out), W'(exp_c));
        check({tag, "_V"}, W'(bus.V), W'(exp_v));
    endtask

    task automatic release_start(input string tag, input logic [W-1:0] exp_s);
        bus.Start = 1'b0;
        tick();
        check({tag, "_rel_done"}, W'(bus.Done), W'(0));
        check({tag, "_rel_busy"}, W'(bus.Busy), W'(0));
        check({tag, "_rel_S"}, bus.S, exp_s);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        Reset = 1'b1;
        bus.Start = 1'b0; bus.Sub = 1'b0; bus.A = '0; bus.B = '0;
        #12;
        check("rst_S", bus.S, '0);
        check("rst_flags", W'({bus.C_out, bus.V, bus.Busy, bus.Done}), W'(0));
        Reset = 1'b0;
        tick();

        do_op("carry", 64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 64'h0000_0000_0001_0000, 1'b0, 1'b0);
        release_start("carry", 64'h0000_0000_0001_0000);

        do_op("wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0, 1'b1, 1'b0);
        release_start("wrap", 64'h0);

        do_op("sub_borrow", 64'h5, 64'h7, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
        release_start("sub_borrow", 64'hFFFF_FFFF_FFFF_FFFE);

        do_op("sub_equal", 64'h7, 64'h7, 1'b1, 64'h0, 1'b1, 1'b0);
        release_start("sub_equal", 64'h0);

        do_op("ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1);
        // Start still held: must stay in DONE with no second operation.
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold_done", W'(bus.Done), W'(1));
            check("hold_busy", W'(bus.Busy), W'(0));
            check("hold_S", bus.S, 64'h8000_0000_0000_0000);
        end
        release_start("ovf", 64'h8000_0000_0000_0000);

        // Reset at k=2 with Start still high; check without any clock edge.
        bus.A = 64'h1234_5678_9ABC_DEF0; bus.B = 64'h1111_1111_1111_1111;
        bus.Sub = 1'b0; bus.Start = 1'b1;
        tick();
        tick();
        tick();
        check("midop_busy", W'(bus.Busy), W'(1));
        #3;
        Reset = 1'b1;
        #1;
        check("async_rst_S", bus.S, '0);
        check("async_rst_flags", W'({bus.C_out, bus.V, bus.Busy, bus.Done}), W'(0));
        #1;
        Reset = 1'b0;
        do_op("restart", 64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b0,
              64'h2345_6789_ABCD_F001, 1'b0, 1'b0);
        release_start("restart", 64'h2345_6789_ABCD_F001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
